delay_queue: RTL

DELAY_QUEUE -- requirements
Module: Delay_queue

---
 rtl/delay_queue_pkg.sv | 16 +
 rtl/delay_queue_ptr.sv | 34 +++
 rtl/delay_queue.sv | 83 ++++++++
 3 files changed

// File: rtl/delay_queue_pkg.sv
// Shared sizing helpers for the delay queue: pointer and occupancy widths derived from DEPTH.
package delay_queue_pkg;

    localparam int DQ_DEFAULT_WIDTH = 4;
    localparam int DQ_DEFAULT_DEPTH = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count must represent 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_queue_ptr.sv
// Wrapping modulo-DEPTH pointer with increment enable; used for both read and write sides.
module delay_queue_ptr
    import delay_queue_pkg::*;
#(
    parameter  int DEPTH = DQ_DEFAULT_DEPTH,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/delay_queue.sv
// Show-ahead FIFO with registered status flags, sticky error flag and async-cleared register storage.
module delay_queue
    import delay_queue_pkg::*;
#(
    parameter  int WIDTH = DQ_DEFAULT_WIDTH,
    parameter  int DEPTH = DQ_DEFAULT_DEPTH,
    localparam int PW    = ptr_width(DEPTH),
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             err_q;
    logic             err_d;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_acc;
    logic             pop_acc;

    // Acceptance is judged on pre-edge occupancy; full/empty come straight from count_q.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;

    delay_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .inc_i (push_acc),
        .ptr_o (wr_ptr)
    );

    delay_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .inc_i (pop_acc),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A push+pop pair always resolves into one real transfer, so only a lone rejected request is an error.
        err_d = err_q | (push && full && !pop) | (pop && empty && !push);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            if (push_acc) begin
                mem_q[wr_ptr] <= in;
            end
        end
    end

    assign out   = mem_q[rd_ptr];
    assign count = count_q;
    assign err   = err_q;

endmodule
